instr_fetch_unit: RTL and testbench

Fetch stage directly upstream of the control-path decoder in the single-issue RISC-V core. Holds the PC and issues one instruction-memory request at a time over a valid/ready interface. Captures the returned word and presents it, with the opcode/funct3/funct7/register fields split out, to the decoder under a valid/ready handshake. Accepts branch redirects from execute and squashes any in-flight fetch.

---
 rtl/ifetch_pkg.sv | 28 ++
 rtl/instr_field_split.sv | 21 ++
 rtl/instr_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared fetch/decode definitions: FSM encoding, idle instruction, RV32 field
// positions and the base opcodes the control path also decodes.
package ifetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned OPC_LSB    = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_LSB = 25;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of a 32-bit RV32 instruction word into its fixed fields.
module instr_field_split
  import ifetch_pkg::*;
(
  input  logic [31:0] word,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  assign opcode = word[OPC_LSB    +: 7];
  assign rd     = word[RD_LSB     +: 5];
  assign funct3 = word[FUNCT3_LSB +: 3];
  assign rs1    = word[RS1_LSB    +: 5];
  assign rs2    = word[RS2_LSB    +: 5];
  assign funct7 = word[FUNCT7_LSB +: 7];

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch stage feeding the decoder.
// Define IFETCH_MISALIGN_CHK_EN to trap misaligned redirects (S_ERR, sticky fetch_err).
module instr_fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = ifetch_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [31:0]        imem_resp_data,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic [XLEN-1:0]    instr_pc,
  output logic [6:0]         opcode,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic               fetch_err,
  output ifetch_pkg::state_e dbg_state
);
  import ifetch_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // depends only on registered state, and the holder keeps data stable until then.

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            squash_q, squash_d;
  logic [XLEN-1:0] target_capt;
  logic            misalign;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic err_q;

  assign target_capt = branch_target;
  assign misalign    = (branch_target[1:0] != 2'b00);
  assign fetch_err   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (branch_taken && misalign) begin
      err_q <= 1'b1;
    end
  end
`else
  assign target_capt = branch_target & ~XLEN'(3);
  assign misalign    = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      squash_q   <= squash_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    squash_d   = squash_q;

    case (state_q)
      S_FETCH: if (imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = S_FETCH;
          end else begin
            instr_d    = imem_resp_data;
            instr_pc_d = pc_q;
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_FETCH;
        end
      end
      default: ;
    endcase

    // A redirect overrides everything above; a response arriving alongside it is dropped.
    if (branch_taken) begin
      pc_d = target_capt;
      if (state_q != S_ERR) begin
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
          S_FETCH: begin
            if (imem_req_ready) begin
              state_d  = S_WAIT;
              squash_d = 1'b1;
            end else begin
              state_d = S_FETCH;
            end
          end
          S_WAIT: begin
            if (imem_resp_valid) begin
              state_d  = S_FETCH;
              squash_d = 1'b0;
            end else begin
              state_d  = S_WAIT;
              squash_d = 1'b1;
            end
          end
          default: state_d = S_FETCH;
        endcase
        if (misalign) begin
          state_d  = S_ERR;
          squash_d = 1'b0;
        end
      end
    end
  end

  assign imem_req_valid = (state_q == S_FETCH) && reset;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (state_q == S_HOLD);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign dbg_state      = state_q;

  instr_field_split u_split (
    .word   (instr_q),
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: reset checks, decode table, directed redirect
// corners and a randomized run against a transaction-level PC/memory model.
module tb_instr_fetch_unit;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data;
  logic        branch_taken, instr_valid, instr_ready, fetch_err;
  logic [31:0] branch_target, instr, instr_pc;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  state_e      dbg_state;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .fetch_err(fetch_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
  } vec_t;
  vec_t tbl [6];

  int checks = 0;
  int failures = 0;
  int delivered = 0;

  // Memory model: word per address, one pending request, fixed latency at accept.
  logic [31:0] mem_aa [logic [31:0]];
  int          mem_delay = 1;
  bit          pend = 0;
  int          rem = 0;
  logic [31:0] paddr = '0;

  // Reference: the PC the stage must be working on, moved only by redirects and consumes.
  logic [31:0] model_pc = '0;
  bit          model_err = 0;

  function automatic logic [31:0] word_of(logic [31:0] a);
    if (mem_aa.exists(a)) return mem_aa[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: check outputs, update model, then drive the memory response for the next cycle.
  task automatic tick();
    bit          acc;
    logic [31:0] acc_addr;
    @(negedge clk);
    if (model_err) begin
      check("err_req_valid", imem_req_valid, 0);
      check("err_instr_valid", instr_valid, 0);
    end else begin
      if (imem_req_valid) check("req_addr", imem_req_addr, model_pc);
      if (instr_valid) begin
        check("instr_pc", instr_pc, model_pc);
        check("instr_word", instr, word_of(model_pc));
      end
    end
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    if (branch_taken) begin
`ifdef IFETCH_MISALIGN_CHK_EN
      model_pc = branch_target;
      if (branch_target[1:0] != 2'b00) model_err = 1;
`else
      model_pc = {branch_target[31:2], 2'b00};
`endif
    end else if (instr_valid && instr_ready && !model_err) begin
      model_pc = model_pc + 32'd4;
      delivered++;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      pend  = 1;
      rem   = mem_delay;
      paddr = acc_addr;
    end
    imem_resp_valid = 1'b0;
    if (pend) begin
      rem--;
      if (rem == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = word_of(paddr);
        pend = 0;
      end
    end
  endtask

  task automatic until_instr(string name);
    int n = 0;
    while (!instr_valid && n < 40) begin
      tick();
      n++;
    end
    check(name, instr_valid, 1);
  endtask

  task automatic until_req(string name);
    int n = 0;
    while (!imem_req_valid && n < 40) begin
      check({name, "_no_instr"}, instr_valid, 0);
      tick();
      n++;
    end
    check(name, imem_req_valid, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
    branch_taken = 0; branch_target = '0; instr_ready = 0;
    pend = 0; mem_delay = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_fetch_err", fetch_err, 0);
    check("rst_state", dbg_state, S_FETCH);
    check("rst_opcode", opcode, 7'h13);
    @(negedge clk);
    reset = 1'b1;
    model_pc = 32'h0;
    model_err = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(logic [31:0] tgt);
    branch_taken  = 1'b1;
    branch_target = tgt;
    tick();
    branch_taken  = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] held;

    tbl[0] = '{32'h002081B3, 7'h33, 3'd0, 7'h00, 5'd3,  5'd1, 5'd2};
    tbl[1] = '{32'h00500093, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0, 5'd5};
    tbl[2] = '{32'h407302B3, 7'h33, 3'd0, 7'h20, 5'd5,  5'd6, 5'd7};
    tbl[3] = '{32'h00812503, 7'h03, 3'd2, 7'h00, 5'd10, 5'd2, 5'd8};
    tbl[4] = '{32'h00322623, 7'h23, 3'd2, 7'h00, 5'd12, 5'd4, 5'd3};
    tbl[5] = '{32'hFFFFFFFF, 7'h7F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31};
    mem_aa[32'h0] = tbl[0].word;
    for (int i = 0; i < 6; i++) mem_aa[32'h400 + 32'(4 * i)] = tbl[i].word;

    #3;
    // First fetch: zero-wait memory, decoder always ready.
    do_reset();
    imem_req_ready = 1; instr_ready = 1;
    check("t1_req_valid", imem_req_valid, 1);
    check("t1_req_addr", imem_req_addr, 32'h0);
    tick();
    n = 1;
    while (!instr_valid && n < 10) begin
      tick();
      n++;
    end
    check("t1_latency", n, 2);
    check("t1_opcode", opcode, 7'h33);
    check("t1_funct3", funct3, 0);
    check("t1_funct7", funct7, 0);
    check("t1_rd", rd, 3);
    check("t1_rs1", rs1, 1);
    check("t1_rs2", rs2, 2);
    tick();
    check("t1_next_addr", imem_req_addr, 32'h4);

    // Decoder stall in hold.
    instr_ready = 0;
    until_instr("t2_valid");
    held = instr;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", instr_valid, 1);
      check("t2_hold_instr", instr, held);
      check("t2_no_req", imem_req_valid, 0);
      tick();
    end
    instr_ready = 1;
    tick();
    check("t2_next_addr", imem_req_addr, 32'h8);

    // Redirect coinciding with the response for PC 4.
    do_reset();
    imem_req_ready = 1; instr_ready = 1;
    n = 0;
    while (!(imem_resp_valid && paddr == 32'h4) && n < 20) begin
      tick();
      n++;
    end
    check("t3_resp_seen", imem_resp_valid, 1);
    redirect(32'h100);
    check("t3_dropped", instr_valid, 0);
    check("t3_req_valid", imem_req_valid, 1);
    check("t3_req_addr", imem_req_addr, 32'h100);

    // Redirect while waiting; late response must be squashed.
    do_reset();
    imem_req_ready = 1; instr_ready = 1; mem_delay = 4;
    tick();
    check("t4_in_wait", dbg_state, S_WAIT);
    redirect(32'h200);
    until_req("t4_req_valid");
    check("t4_req_addr", imem_req_addr, 32'h200);
    mem_delay = 1;
    until_instr("t4_refetch");
    check("t4_instr_pc", instr_pc, 32'h200);
    check("t4_instr", instr, word_of(32'h200));

    // Redirect in hold with decoder ready the same cycle.
    do_reset();
    imem_req_ready = 1; instr_ready = 1;
    until_instr("t5_valid");
    redirect(32'h300);
    check("t5_dropped", instr_valid, 0);
    check("t5_req_addr", imem_req_addr, 32'h300);

    // PC wrap at the top of the address space.
    imem_req_ready = 0;
    redirect(32'hFFFF_FFFC);
    imem_req_ready = 1;
    until_instr("wrap_valid");
    check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_next_addr", imem_req_addr, 32'h0);

    // Decode table through the pipeline.
    do_reset();
    imem_req_ready = 1; instr_ready = 1;
    redirect(32'h400);
    for (int i = 0; i < 6; i++) begin
      until_instr("tbl_valid");
      check("tbl_opcode", opcode, tbl[i].op);
      check("tbl_funct3", funct3, tbl[i].f3);
      check("tbl_funct7", funct7, tbl[i].f7);
      check("tbl_rd", rd, tbl[i].rd);
      check("tbl_rs1", rs1, tbl[i].rs1);
      check("tbl_rs2", rs2, tbl[i].rs2);
      tick();
    end

    // Misaligned redirect.
    do_reset();
    imem_req_ready = 0;
    redirect(32'h102);
`ifdef IFETCH_MISALIGN_CHK_EN
    check("t6_fetch_err", fetch_err, 1);
    check("t6_state", dbg_state, S_ERR);
    imem_req_ready = 1; instr_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("t6_no_req", imem_req_valid, 0);
      tick();
    end
    check("t6_sticky", fetch_err, 1);
`else
    check("t6_fetch_err", fetch_err, 0);
    check("t6_req_addr", imem_req_addr, 32'h100);
`endif

    // Randomized traffic against the model.
    do_reset();
    delivered = 0;
    for (int c = 0; c < 4000; c++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 2) != 0);
      mem_delay      = $urandom_range(1, 3);
      branch_taken   = ($urandom_range(0, 15) == 0);
`ifdef IFETCH_MISALIGN_CHK_EN
      branch_target  = $urandom() & 32'hFFFF_FFFC;
`else
      branch_target  = $urandom();
`endif
      tick();
    end
    branch_taken = 0;
    checks++;
    if (delivered < 100) begin
      failures++;
      $display("FAIL rand_progress: got %0d delivered expected at least 100", delivered);
    end
    check("rand_fetch_err", fetch_err, 0);

    // Reset with a request outstanding.
    imem_req_ready = 1; mem_delay = 3;
    n = 0;
    while (!pend && n < 40) begin
      tick();
      n++;
    end
    do_reset();
    check("midrst_req_addr", imem_req_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
